// File: rtl/i2s_frame_sched_pkg.sv
// Shared definitions for the I2S frame scheduler.
//   FRAME_BITS    - frame length in bit clocks for the default slot width
//   frame_bits()  - frame length for an arbitrary slot width
//   pos_w()       - width of the bit_pos counter for a given slot width
//   state_t       - scheduler state encoding (IDLE / RUN)
package i2s_pkg;

    localparam int WORD_DEF   = 64;
    localparam int FRAME_BITS = 2 * WORD_DEF;

    function automatic int frame_bits(input int word);
        return 2 * word;
    endfunction

    function automatic int pos_w(input int word);
        return $clog2(2 * word);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_frame_sched_if.sv
// Upstream sample source handshake (valid/ready with a stereo payload).
//   s_valid  - source has a sample
//   s_ready  - scheduler will take it this cycle
//   s_left   - left channel sample
//   s_right  - right channel sample
// master = sample source (mixer/FIFO), slave = scheduler.
interface i2s_src_if #(
    parameter int BITSIZE = 16
);
    import i2s_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [BITSIZE-1:0] s_left;
    logic [BITSIZE-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/i2s_frame_sched_counter.sv
// Free-running frame position counter for the I2S bit clock.
//   sclk, rst    - bit clock, async active-high reset
//   bit_pos      - position in frame, 0 .. 2*WORD-1, wraps forever
//   lrclk        - registered word select, 1 while bit_pos >= WORD
//   frame_start  - registered, high during the bit_pos == 0 cycle
//   frame_end    - combinational, high during the last cycle of the frame
module i2s_frame_counter
    import i2s_pkg::*;
#(
    parameter  int WORD = 64,
    localparam int PW   = pos_w(WORD)
) (
    input  logic          sclk,
    input  logic          rst,
    output logic [PW-1:0] bit_pos,
    output logic          lrclk,
    output logic          frame_start,
    output logic          frame_end
);

    localparam int FB = frame_bits(WORD);

    logic [PW-1:0] pos_nxt;

    assign frame_end = (bit_pos == PW'(FB - 1));
    assign pos_nxt   = frame_end ? '0 : bit_pos + PW'(1);

    // lrclk and frame_start are derived from the next position so they line
    // up with bit_pos in the same cycle while still coming from flops.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            bit_pos     <= '0;
            lrclk       <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            bit_pos     <= pos_nxt;
            lrclk       <= (pos_nxt >= PW'(WORD));
            frame_start <= (pos_nxt == '0);
        end
    end

endmodule

// File: rtl/i2s_frame_sched.sv
// I2S frame scheduler and sample feeder. Fetches one stereo sample per frame
// from the upstream source and presents it, stable for a whole frame, to the
// I2S transmitter; a frame with no sample is flagged and counted as underrun.
//   sclk, rst       - bit clock, async active-high reset
//   enable          - stream request, sampled at frame end only
//   cnt_clr         - synchronous clear of underrun_count (wins over increment)
//   src             - upstream sample handshake (slave side)
//   lrclk           - word select, 0 = left slot, 1 = right slot
//   left_chan/right_chan - words to the transmitter, change at frame end only
//   frame_start     - high during bit_pos == 0
//   underrun        - one-cycle pulse after a frame with no sample
//   underrun_count  - saturating underrun count
//   running         - streaming active
module i2s_frame_sched
    import i2s_pkg::*;
#(
    parameter  int BITSIZE   = 16,
    parameter  int WORD      = 64,
    parameter  int FETCH_POS = 64,
    parameter  int HOLD_LAST = 0,
    parameter  int CNT_W     = 16,
    localparam int PW        = pos_w(WORD)
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cnt_clr,
    i2s_src_if.slave           src,
    output logic               lrclk,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               frame_start,
    output logic               underrun,
    output logic [CNT_W-1:0]   underrun_count,
    output logic               running
);

    state_t             state;
    logic [PW-1:0]      bit_pos;
    logic               frame_end;
    logic               pend_valid;
    logic [BITSIZE-1:0] pend_left;
    logic [BITSIZE-1:0] pend_right;
    logic               hs;

    i2s_frame_counter #(.WORD(WORD)) u_cnt (
        .sclk        (sclk),
        .rst         (rst),
        .bit_pos     (bit_pos),
        .lrclk       (lrclk),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign running     = (state == RUN);
    // A full pending slot blocks further fetches, limiting intake to one
    // sample per frame.
    assign src.s_ready = running & ~pend_valid & (bit_pos >= PW'(FETCH_POS));
    assign hs          = src.s_valid & src.s_ready;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend_valid     <= 1'b0;
            pend_left      <= '0;
            pend_right     <= '0;
            left_chan      <= '0;
            right_chan     <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= 1'b0;
            if (frame_end) begin
                // Transfer decisions use the running value of the closing frame.
                state      <= enable ? RUN : IDLE;
                pend_valid <= 1'b0;
                if (state == IDLE) begin
                    left_chan  <= '0;
                    right_chan <= '0;
                end else if (pend_valid) begin
                    left_chan  <= pend_left;
                    right_chan <= pend_right;
                end else if (hs) begin
                    // Late sample accepted on the last bit: bypass the pending slot.
                    left_chan  <= src.s_left;
                    right_chan <= src.s_right;
                end else begin
                    underrun <= 1'b1;
                    if (underrun_count != '1)
                        underrun_count <= underrun_count + CNT_W'(1);
                    if (HOLD_LAST == 0) begin
                        left_chan  <= '0;
                        right_chan <= '0;
                    end
                end
            end else if (hs) begin
                pend_left  <= src.s_left;
                pend_right <= src.s_right;
                pend_valid <= 1'b1;
            end
            if (cnt_clr)
                underrun_count <= '0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Directed bench for i2s_frame_sched. dut0 uses the default parameters
// (zero on underrun); dut1 holds the last sample and has a 3-bit counter so
// saturation is reachable. Both see identical stimulus.
module tb_i2s_frame_sched;

    logic        sclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cnt_clr;
    logic        valid;
    logic [15:0] left;
    logic [15:0] right;

    logic        lrclk0, fs0, ur0, run0;
    logic [15:0] lc0, rc0, cnt0;
    logic        lrclk1, fs1, ur1, run1;
    logic [15:0] lc1, rc1;
    logic [2:0]  cnt1;

    int n_cmp = 0;
    int n_err = 0;
    int pos;
    int hs_frame;

    always #5 sclk = ~sclk;

    i2s_src_if #(.BITSIZE(16)) src0 ();
    i2s_src_if #(.BITSIZE(16)) src1 ();

    assign src0.s_valid = valid;
    assign src0.s_left  = left;
    assign src0.s_right = right;
    assign src1.s_valid = valid;
    assign src1.s_left  = left;
    assign src1.s_right = right;

    i2s_frame_sched #(.BITSIZE(16), .WORD(64), .FETCH_POS(64), .HOLD_LAST(0), .CNT_W(16)) dut0 (
        .sclk(sclk), .rst(rst), .enable(enable), .cnt_clr(cnt_clr), .src(src0),
        .lrclk(lrclk0), .left_chan(lc0), .right_chan(rc0), .frame_start(fs0),
        .underrun(ur0), .underrun_count(cnt0), .running(run0)
    );

    i2s_frame_sched #(.BITSIZE(16), .WORD(64), .FETCH_POS(64), .HOLD_LAST(1), .CNT_W(3)) dut1 (
        .sclk(sclk), .rst(rst), .enable(enable), .cnt_clr(cnt_clr), .src(src1),
        .lrclk(lrclk1), .left_chan(lc1), .right_chan(rc1), .frame_start(fs1),
        .underrun(ur1), .underrun_count(cnt1), .running(run1)
    );

    // Reference frame position, independent of the DUT.
    always @(posedge sclk or posedge rst) begin
        if (rst) pos <= 0;
        else     pos <= (pos == 127) ? 0 : pos + 1;
    end

    // Handshakes seen so far in the current frame.
    always @(negedge sclk) begin
        if (pos == 0) hs_frame <= int'(valid && src0.s_ready);
        else if (valid && src0.s_ready) hs_frame <= hs_frame + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)", tag, got, exp, pos, $time);
        end
    endtask

    // Advance to 1 time unit after the edge that lands on position p.
    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(posedge sclk);
            #1;
            n++;
        end while (pos != p && n < 300);
        if (pos != p) chk("wait_timeout", pos, p);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cnt_clr = 1'b0; valid = 1'b0; left = '0; right = '0;
        #2;
        chk("rst_fs", fs0, 1);
        chk("rst_lrclk", lrclk0, 0);
        chk("rst_run", run0, 0);
        chk("rst_left", lc0, 0);
        chk("rst_right", rc0, 0);
        chk("rst_ready", src0.s_ready, 0);
        chk("rst_ur", ur0, 0);
        chk("rst_cnt", cnt0, 0);
        repeat (3) @(posedge sclk);
        @(negedge sclk) rst = 1'b0;

        // Three idle frames: timing only.
        for (int c = 0; c < 384; c++) begin
            @(posedge sclk);
            #1;
            if (pos == 0 || pos == 63 || pos == 64 || pos == 127) begin
                chk("idle_fs", fs0, (pos == 0));
                chk("idle_lrclk", lrclk0, (pos >= 64));
                chk("idle_ready", src0.s_ready, 0);
                chk("idle_left", lc0, 0);
            end
        end

        // Startup: enable mid frame 0.
        wait_pos(10);
        enable = 1'b1; valid = 1'b1; left = 16'h1234; right = 16'hABCD;
        chk("f0_run", run0, 0);
        wait_pos(0);
        chk("f1_run", run0, 1);
        chk("f1_left", lc0, 0);
        wait_pos(63);
        chk("f1_ready63", src0.s_ready, 0);
        wait_pos(64);
        chk("f1_ready64", src0.s_ready, 1);
        wait_pos(65);
        chk("f1_ready65", src0.s_ready, 0);
        wait_pos(127);
        chk("f1_hs", hs_frame, 1);
        chk("f1_left_end", lc0, 0);
        wait_pos(0);
        chk("f2_left", lc0, 16'h1234);
        chk("f2_right", rc0, 16'hABCD);
        chk("f2_left1", lc1, 16'h1234);
        wait_pos(1);
        left = 16'h1111; right = 16'h2222;
        wait_pos(100);
        valid = 1'b0;
        chk("f2_hs", hs_frame, 1);

        // Two underruns.
        wait_pos(0);
        chk("f3_left", lc0, 16'h1111);
        chk("f3_right", rc0, 16'h2222);
        chk("f3_ur", ur0, 0);
        wait_pos(127);
        chk("f3_ur127", ur0, 0);
        wait_pos(0);
        chk("f4_ur", ur0, 1);
        chk("f4_cnt", cnt0, 1);
        chk("f4_left0", lc0, 0);
        chk("f4_right0", rc0, 0);
        chk("f4_hold_l", lc1, 16'h1111);
        chk("f4_hold_r", rc1, 16'h2222);
        wait_pos(1);
        chk("f4_ur_pulse", ur0, 0);
        wait_pos(0);
        chk("f5_ur", ur0, 1);
        chk("f5_cnt", cnt0, 2);
        chk("f5_cnt1", cnt1, 2);
        chk("f5_left0", lc0, 0);
        chk("f5_hold_l", lc1, 16'h1111);

        // Sample offered only on the last bit of the frame.
        wait_pos(127);
        valid = 1'b1; left = 16'h7777; right = 16'h8888;
        chk("f5_ready127", src0.s_ready, 1);
        wait_pos(0);
        valid = 1'b0;
        chk("f6_left", lc0, 16'h7777);
        chk("f6_right", rc0, 16'h8888);
        chk("f6_ur", ur0, 0);
        chk("f6_cnt", cnt0, 2);
        chk("f6_left1", lc1, 16'h7777);
        wait_pos(10);
        cnt_clr = 1'b1;
        wait_pos(11);
        cnt_clr = 1'b0;
        chk("clr_cnt0", cnt0, 0);
        chk("clr_cnt1", cnt1, 0);
        wait_pos(64);
        chk("f6_ready_nopend", src0.s_ready, 1);

        // 11 underruns: 3-bit counter saturates at 7.
        repeat (11) wait_pos(0);
        chk("sat_cnt0", cnt0, 11);
        chk("sat_cnt1", cnt1, 7);
        chk("sat_hold", lc1, 16'h7777);
        wait_pos(127);
        cnt_clr = 1'b1;
        wait_pos(0);
        cnt_clr = 1'b0;
        chk("clr_ur_pulse", ur0, 1);
        chk("clr_ur_cnt0", cnt0, 0);
        chk("clr_ur_cnt1", cnt1, 0);

        // Stop mid-frame with a sample fetched in that frame.
        wait_pos(1);
        valid = 1'b1; left = 16'h9999; right = 16'hAAAA;
        wait_pos(70);
        enable = 1'b0; valid = 1'b0;
        wait_pos(0);
        chk("stop_run", run0, 0);
        chk("stop_left", lc0, 16'h9999);
        chk("stop_right", rc0, 16'hAAAA);
        chk("stop_ur", ur0, 0);
        wait_pos(64);
        chk("stop_ready", src0.s_ready, 0);
        wait_pos(0);
        chk("stop_left0", lc0, 0);
        chk("stop_left1", lc1, 0);
        chk("stop_ur2", ur0, 0);

        // Restart, then reset mid-frame with a pending sample.
        enable = 1'b1; valid = 1'b1; left = 16'hBBBB; right = 16'hCCCC;
        wait_pos(0);
        chk("re_run", run0, 1);
        wait_pos(0);
        chk("re_left", lc0, 16'hBBBB);
        chk("re_right", rc0, 16'hCCCC);
        wait_pos(90);
        chk("re_lrclk", lrclk0, 1);
        rst = 1'b1;
        valid = 1'b0;
        #1;
        chk("mrst_run", run0, 0);
        chk("mrst_left", lc0, 0);
        chk("mrst_right", rc0, 0);
        chk("mrst_left1", lc1, 0);
        chk("mrst_lrclk", lrclk0, 0);
        chk("mrst_fs", fs0, 1);
        chk("mrst_ready", src0.s_ready, 0);
        repeat (2) @(posedge sclk);
        @(negedge sclk) rst = 1'b0;
        wait_pos(1);
        chk("post_fs", fs0, 0);
        chk("post_run", run0, 0);
        wait_pos(64);
        chk("post_lrclk", lrclk0, 1);
        chk("post_ready", src0.s_ready, 0);
        wait_pos(0);
        chk("post_run2", run0, 1);
        chk("post_left", lc0, 0);
        wait_pos(64);
        chk("post_ready_pend", src0.s_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
